// File: rtl/paridade_tx_serial_pkg.sv
// Shared definitions for the serial parity transmitter and its receive-side checker.
// Holds the FSM state type, the frame line levels and the parity helper so both ends
// of the link agree on framing and parity polarity.
package paridade_tx_serial_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Widest word parity_of accepts; narrower words are zero-extended, which keeps the XOR.
  localparam int unsigned PARITY_MAX_W = 64;

  // Even parity: XOR of the word. Odd parity: XNOR of the word.
  function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/paridade_tx_serial_if.sv
// Parallel-producer side of the transmitter plus its serial/status outputs.
//   data_in    : word to transmit, sampled on the accepting edge
//   start      : send request, accepted when ready is high
//   ready      : transmitter idle
//   tx         : serial line (idles high)
//   parity_out : parity bit of the latched word
//   done       : one-cycle pulse on the last cycle of the stop bit
interface paridade_tx_serial_if #(
  parameter int unsigned DATA_W = 4
) ();

  logic [DATA_W-1:0] data_in;
  logic              start;
  logic              ready;
  logic              tx;
  logic              parity_out;
  logic              done;

  modport master (
    output data_in, start,
    input  ready, tx, parity_out, done
  );

  modport slave (
    input  data_in, start,
    output ready, tx, parity_out, done
  );

endinterface

// File: rtl/paridade_tx_serial_contador_bit.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the wrap cycle.
//   clk, rst_n : clock and asynchronous active-low reset
//   i_en       : count this cycle
//   i_clr      : synchronous clear to zero (has priority over i_en)
//   o_wrap     : high on the enabled cycle where the counter sits at its terminal value
module paridade_tx_serial_contador_bit #(
  parameter int unsigned CLKS_PER_BIT = 4,
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);

  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_d;
  logic            w_last;

  always_comb begin
    w_last    = (r_count == LastCnt);
    o_wrap    = i_en && w_last;
    w_count_d = r_count;
    if (i_clr) begin
      w_count_d = '0;
    end else if (i_en) begin
      w_count_d = w_last ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

endmodule

// File: rtl/paridade_tx_serial.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, parity bit, stop bit,
// each held CLKS_PER_BIT clocks. The parity bit is what the receive-side checker verifies.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of paridade_tx_serial_if (data_in/start in; ready, tx,
//                parity_out, done out)
module paridade_tx_serial
  import paridade_tx_serial_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  paridade_tx_serial_if.slave   bus
);

  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

  tx_state_e         r_state, w_state_d;
  logic [DATA_W-1:0] r_shift, w_shift_d;
  logic [IdxW-1:0]   r_idx, w_idx_d;
  logic              r_parity, w_parity_d;
  logic              r_tx, w_tx_d;

  logic                    w_wrap;
  logic [DATA_W-1:0]       w_shift_next;
  logic [PARITY_MAX_W-1:0] w_word_ext;

  paridade_tx_serial_contador_bit #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_contador_bit (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state != StIdle),
    .i_clr  (r_state == StIdle),
    .o_wrap (w_wrap)
  );

  always_comb begin
    w_word_ext               = '0;
    w_word_ext[DATA_W-1:0]   = bus.data_in;
    w_shift_next             = r_shift >> 1;

    w_state_d  = r_state;
    w_shift_d  = r_shift;
    w_idx_d    = r_idx;
    w_parity_d = r_parity;
    w_tx_d     = r_tx;

    case (r_state)
      StIdle: begin
        w_tx_d  = IDLE_LEVEL;
        w_idx_d = '0;
        if (bus.start) begin
          w_shift_d  = bus.data_in;
          w_parity_d = parity_of(w_word_ext, PARITY_ODD);
          w_tx_d     = START_BIT;
          w_state_d  = StStart;
        end
      end
      StStart: begin
        if (w_wrap) begin
          w_tx_d    = r_shift[0];
          w_idx_d   = '0;
          w_state_d = StData;
        end
      end
      StData: begin
        if (w_wrap) begin
          w_shift_d = w_shift_next;
          if (r_idx == LastIdx) begin
            w_tx_d    = r_parity;
            w_state_d = StParity;
          end else begin
            // Next data bit is bit 0 of the shifted word.
            w_tx_d  = w_shift_next[0];
            w_idx_d = r_idx + 1'b1;
          end
        end
      end
      StParity: begin
        if (w_wrap) begin
          w_tx_d    = STOP_BIT;
          w_state_d = StStop;
        end
      end
      StStop: begin
        if (w_wrap) begin
          w_tx_d    = IDLE_LEVEL;
          w_state_d = StIdle;
        end
      end
      default: begin
        // Unused encodings fall back to a clean idle line.
        w_tx_d    = IDLE_LEVEL;
        w_idx_d   = '0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_shift  <= '0;
      r_idx    <= '0;
      r_parity <= 1'b0;
      r_tx     <= IDLE_LEVEL;
    end else begin
      r_state  <= w_state_d;
      r_shift  <= w_shift_d;
      r_idx    <= w_idx_d;
      r_parity <= w_parity_d;
      r_tx     <= w_tx_d;
    end
  end

  assign bus.ready      = (r_state == StIdle);
  assign bus.tx         = r_tx;
  assign bus.parity_out = r_parity;
  assign bus.done       = (r_state == StStop) && w_wrap;

endmodule
